// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write-back path.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } rf_byp_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Pending-write buffer: circular FIFO with two pushes and one pop per edge.
// Entries, valid mask and head index are exposed for the bypass search.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push0,
  input  logic [REG_ADDR_W-1:0]          wr0Rw,
  input  logic [DATA_W-1:0]              wr0Data,
  input  logic                           push1,
  input  logic [REG_ADDR_W-1:0]          wr1Rw,
  input  logic [DATA_W-1:0]              wr1Data,
  input  logic                           pop,
  output logic [CNT_W-1:0]               count,
  output logic [IDX_W-1:0]               head,
  output logic [DEPTH-1:0]               valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entRw,
  output logic [DEPTH-1:0][DATA_W-1:0]   entData
);

  rf_wr_t           mem [DEPTH];
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] tail1;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [IDX_W-1:0] ptrInc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Lane 1 lands behind lane 0 when both push, otherwise at the tail itself.
  assign tail1 = push0 ? ptrInc(tail) : tail;

  // NOTE: storage has no reset; an entry is only observed once count covers it.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (push0) mem[tail]  <= '{rw: wr0Rw, data: wr0Data};
    if (push1) mem[tail1] <= '{rw: wr1Rw, data: wr1Data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= ptrInc(head);
      if (push0 || push1) tail <= push1 ? ptrInc(tail1) : tail1;
      count <= count - CNT_W'(pop) + CNT_W'(push0) + CNT_W'(push1);
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default first so no latch is inferred.
    valid = '0;
    idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) valid[idx] = 1'b1;
      idx = ptrInc(idx);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entRw[i]   = mem[i].rw;
      entData[i] = mem[i].data;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: accepts up to
// two lane writes per cycle, drains one per cycle and bypasses pending data.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rw,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rw,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0]     rf_inW,
  input  logic [REG_ADDR_W-1:0] byp_ra,
  input  logic [REG_ADDR_W-1:0] byp_rb,
  output logic                  byp_a_hit,
  output logic [DATA_W-1:0]     byp_a_data,
  output logic                  byp_b_hit,
  output logic [DATA_W-1:0]     byp_b_data,
  output logic [CNT_W-1:0]      pending,
  output logic                  idle
);

  logic [CNT_W-1:0]                count;
  logic [CNT_W-1:0]                free;
  logic [IDX_W-1:0]                head;
  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entRw;
  logic [DEPTH-1:0][DATA_W-1:0]    entData;
  logic                            lane0Fits;
  logic                            push0;
  logic                            push1;
  logic                            pop;
  rf_byp_t                         bypA;
  rf_byp_t                         bypB;

  // The same-cycle pop earns no credit: free reflects pre-edge occupancy.
  assign free      = CNT_W'(DEPTH) - count;
  assign lane0Fits = free >= CNT_W'(1);
  assign push0     = req0_valid && req0_ready && (req0_rw != REG_ZERO);
  assign push1     = req1_valid && req1_ready && (req1_rw != REG_ZERO);
  assign pop       = count != '0;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      req0_ready = lane0Fits;
      if (req0_valid && !lane0Fits)
        req1_ready = 1'b0;
      else if (req0_valid && (req0_rw != REG_ZERO))
        req1_ready = free >= CNT_W'(2);
      else
        req1_ready = lane0Fits;
    end
  end

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push0   (push0),
    .wr0Rw   (req0_rw),
    .wr0Data (req0_data),
    .push1   (push1),
    .wr1Rw   (req1_rw),
    .wr1Data (req1_data),
    .pop     (pop),
    .count   (count),
    .head    (head),
    .valid   (valid),
    .entRw   (entRw),
    .entData (entData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we  <= 1'b0;
      rf_rw  <= REG_ZERO;
      rf_inW <= '0;
    end else if (pop) begin
      rf_we  <= 1'b1;
      rf_rw  <= entRw[head];
      rf_inW <= entData[head];
    end else begin
      rf_we  <= 1'b0;
    end
  end

  // Walk oldest to youngest so the entry nearest the tail overrides the rest.
  function automatic rf_byp_t bypLookup(
    input logic [REG_ADDR_W-1:0]          addr,
    input logic [IDX_W-1:0]               hd,
    input logic [DEPTH-1:0]               vld,
    input logic [DEPTH-1:0][REG_ADDR_W-1:0] rws,
    input logic [DEPTH-1:0][DATA_W-1:0]   dats,
    input logic                           outWe,
    input logic [REG_ADDR_W-1:0]          outRw,
    input logic [DATA_W-1:0]              outData
  );
    rf_byp_t          r;
    logic [IDX_W-1:0] idx;
    r = '0;
    if (outWe && (outRw == addr)) r = '{hit: 1'b1, data: outData};
    idx = hd;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[idx] && (rws[idx] == addr)) r = '{hit: 1'b1, data: dats[idx]};
      idx = (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    end
    if (addr == REG_ZERO) r = '0;
    return r;
  endfunction

  always_comb begin
    bypA = bypLookup(byp_ra, head, valid, entRw, entData, rf_we, rf_rw, rf_inW);
    bypB = bypLookup(byp_rb, head, valid, entRw, entData, rf_we, rf_rw, rf_inW);
  end

  assign byp_a_hit  = bypA.hit;
  assign byp_a_data = bypA.data;
  assign byp_b_hit  = bypB.hit;
  assign byp_b_data = bypB.data;
  assign pending    = count;
  assign idle       = (count == '0) && !rf_we;

endmodule
